ex_mc_ctrl: RTL and testbench

- Multi-cycle sequencer for the EX stage and the pipeline stall controller for all pipeline registers (if_id, id_ex, ex_mem, mem_wb).
- Sequences two-cycle MADD/MSUB accumulation and the handshake with the iterative divider.
- Merges IF/ID stall requests with its own into one stall vector, and aborts in-flight work on flush.

---
 rtl/ex_mc_ctrl_pkg.sv | 36 +++
 rtl/ex_mc_ctrl_stall_merge.sv | 25 ++
 rtl/ex_mc_ctrl.sv | 133 +++++++++++++
 tb/tb_ex_mc_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/ex_mc_ctrl_pkg.sv
// Shared encodings for the EX multi-cycle sequencer and pipeline stall controller.
package ex_mc_ctrl_pkg;

    localparam int unsigned OP_W    = 3;
    localparam int unsigned STALL_W = 6;
    localparam int unsigned DATA_W  = 64;

    typedef enum logic [OP_W-1:0] {
        OP_NONE = 3'b000,
        OP_MADD = 3'b001,
        OP_MSUB = 3'b010,
        OP_DIV  = 3'b011,
        OP_DIVU = 3'b100
    } ex_op_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MADD2    = 2'd1,
        ST_DIV_WAIT = 2'd2,
        ST_DIV_DONE = 2'd3
    } state_e;

    localparam int unsigned BIT_PC  = 0;
    localparam int unsigned BIT_IF  = 1;
    localparam int unsigned BIT_ID  = 2;
    localparam int unsigned BIT_EX  = 3;
    localparam int unsigned BIT_MEM = 4;
    localparam int unsigned BIT_WB  = 5;

    // Each requester holds its own stage and everything upstream of it.
    localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
    localparam logic [STALL_W-1:0] STALL_IF   = 6'b000011;
    localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
    localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;

endpackage

// File: rtl/ex_mc_ctrl_stall_merge.sv
// Priority encoder turning flush/EX/ID/IF requests into the pipeline hold vector.
module ex_mc_ctrl_stall_merge
    import ex_mc_ctrl_pkg::*;
(
    input  logic               flush,
    input  logic               req_ex,
    input  logic               req_id,
    input  logic               req_if,
    output logic [STALL_W-1:0] stall
);

    always_comb begin
        stall = STALL_NONE;
        if (flush) begin
            stall = STALL_NONE;
        end else if (req_ex) begin
            stall = STALL_EX;
        end else if (req_id) begin
            stall = STALL_ID;
        end else if (req_if) begin
            stall = STALL_IF;
        end
    end

endmodule

// File: rtl/ex_mc_ctrl.sv
// EX-stage multi-cycle sequencer (MADD/MSUB, divider handshake) and stall controller.
module ex_mc_ctrl
    import ex_mc_ctrl_pkg::*;
#(
    parameter int unsigned DIV_TIMEOUT = 40,
    parameter int unsigned CNT_W       = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               stallreq_if,
    input  logic               stallreq_id,
    input  logic               ex_valid,
    input  logic [OP_W-1:0]    ex_op,
    input  logic [DATA_W-1:0]  mul_res,
    input  logic               div_ready,
    input  logic [DATA_W-1:0]  div_result,
    output logic [STALL_W-1:0] stall,
    output logic [DATA_W-1:0]  hilo_temp,
    output logic               cnt,
    output logic               div_start,
    output logic               div_signed,
    output logic               div_annul,
    output logic               div_done,
    output logic [DATA_W-1:0]  div_res,
    output logic               div_err
);

    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(DIV_TIMEOUT - 1);

    state_e            state, state_nxt;
    logic [CNT_W-1:0]  wait_cnt, wait_cnt_nxt;
    logic [DATA_W-1:0] hilo_temp_nxt, div_res_nxt;
    logic              div_signed_nxt, div_err_nxt;
    logic              req_ex, annul, clear_stall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            wait_cnt   <= '0;
            hilo_temp  <= '0;
            div_res    <= '0;
            div_signed <= 1'b0;
            div_err    <= 1'b0;
        end else begin
            state      <= state_nxt;
            wait_cnt   <= wait_cnt_nxt;
            hilo_temp  <= hilo_temp_nxt;
            div_res    <= div_res_nxt;
            div_signed <= div_signed_nxt;
            div_err    <= div_err_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        wait_cnt_nxt   = wait_cnt;
        hilo_temp_nxt  = hilo_temp;
        div_res_nxt    = div_res;
        div_signed_nxt = div_signed;
        div_err_nxt    = div_err;
        req_ex         = 1'b0;
        annul          = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (ex_valid) begin
                    case (ex_op_e'(ex_op))
                        OP_MADD: begin
                            hilo_temp_nxt = mul_res;
                            req_ex        = 1'b1;
                            state_nxt     = ST_MADD2;
                        end
                        OP_MSUB: begin
                            hilo_temp_nxt = DATA_W'(0) - mul_res;
                            req_ex        = 1'b1;
                            state_nxt     = ST_MADD2;
                        end
                        OP_DIV, OP_DIVU: begin
                            wait_cnt_nxt   = '0;
                            div_signed_nxt = (ex_op_e'(ex_op) == OP_DIV);
                            req_ex         = 1'b1;
                            state_nxt      = ST_DIV_WAIT;
                        end
                        default: ;
                    endcase
                end
            end
            ST_MADD2: state_nxt = ST_IDLE;
            ST_DIV_WAIT: begin
                req_ex = 1'b1;
                if (div_ready) begin
                    div_res_nxt = div_result;
                    state_nxt   = ST_DIV_DONE;
                end else if (wait_cnt == WAIT_LAST) begin
                    annul       = 1'b1;
                    div_err_nxt = 1'b1;
                    state_nxt   = ST_IDLE;
                end else begin
                    wait_cnt_nxt = wait_cnt + CNT_W'(1);
                end
            end
            ST_DIV_DONE: state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase

        // Flush drops whatever this cycle would have latched and cancels any divide in flight.
        if (flush) begin
            state_nxt      = ST_IDLE;
            wait_cnt_nxt   = wait_cnt;
            hilo_temp_nxt  = hilo_temp;
            div_res_nxt    = div_res;
            div_signed_nxt = div_signed;
            div_err_nxt    = div_err;
            annul          = (state == ST_DIV_WAIT);
        end
    end

    assign cnt         = (state == ST_MADD2);
    assign div_start   = (state == ST_DIV_WAIT);
    assign div_done    = (state == ST_DIV_DONE);
    assign div_annul   = annul;
    assign clear_stall = flush || !rst;

    ex_mc_ctrl_stall_merge u_stall_merge (
        .flush  (clear_stall),
        .req_ex (req_ex),
        .req_id (stallreq_id),
        .req_if (stallreq_if),
        .stall  (stall)
    );

endmodule

// File: tb/tb_ex_mc_ctrl.sv
// Self-checking bench for ex_mc_ctrl: directed vector table, divider sequences, random vs model.
module tb_ex_mc_ctrl;

    localparam int DIV_TIMEOUT = 40;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush, stallreq_if, stallreq_id, ex_valid, div_ready;
    logic [2:0]  ex_op;
    logic [63:0] mul_res, div_result;
    logic [5:0]  stall;
    logic [63:0] hilo_temp, div_res;
    logic        cnt, div_start, div_signed, div_annul, div_done, div_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ex_mc_ctrl #(.DIV_TIMEOUT(40), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .flush(flush), .stallreq_if(stallreq_if),
        .stallreq_id(stallreq_id), .ex_valid(ex_valid), .ex_op(ex_op),
        .mul_res(mul_res), .div_ready(div_ready), .div_result(div_result),
        .stall(stall), .hilo_temp(hilo_temp), .cnt(cnt), .div_start(div_start),
        .div_signed(div_signed), .div_annul(div_annul), .div_done(div_done),
        .div_res(div_res), .div_err(div_err)
    );

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic drive_idle();
        flush = 0; stallreq_if = 0; stallreq_id = 0; ex_valid = 0; ex_op = 3'd0;
        mul_res = '0; div_ready = 0; div_result = '0;
    endtask

    // Behavioural model: tracks which phase of which operation is pending.
    bit          m_second, m_busy, m_done, m_signed, m_err;
    int          m_age;
    logic [63:0] m_hilo, m_res;

    task automatic model_reset();
        m_second = 0; m_busy = 0; m_done = 0; m_signed = 0; m_err = 0;
        m_age = 0; m_hilo = '0; m_res = '0;
    endtask

    task automatic model_check_and_step();
        bit idle, go_madd, go_msub, go_div, go_divu, timeout, req;
        logic [5:0] e_stall;
        idle    = !m_second && !m_busy && !m_done;
        go_madd = idle && ex_valid && ex_op == 3'd1;
        go_msub = idle && ex_valid && ex_op == 3'd2;
        go_div  = idle && ex_valid && ex_op == 3'd3;
        go_divu = idle && ex_valid && ex_op == 3'd4;
        timeout = m_busy && !div_ready && (m_age == DIV_TIMEOUT - 1);
        req     = go_madd || go_msub || go_div || go_divu || m_busy;
        if (flush)            e_stall = 6'b000000;
        else if (req)         e_stall = 6'b001111;
        else if (stallreq_id) e_stall = 6'b000111;
        else if (stallreq_if) e_stall = 6'b000011;
        else                  e_stall = 6'b000000;
        cmp("rnd_stall", 64'(stall), 64'(e_stall));
        cmp("rnd_cnt", 64'(cnt), 64'(m_second));
        cmp("rnd_div_start", 64'(div_start), 64'(m_busy));
        cmp("rnd_div_done", 64'(div_done), 64'(m_done));
        cmp("rnd_div_annul", 64'(div_annul), 64'(m_busy && (flush || timeout)));
        cmp("rnd_hilo_temp", hilo_temp, m_hilo);
        cmp("rnd_div_res", div_res, m_res);
        cmp("rnd_div_signed", 64'(div_signed), 64'(m_signed));
        cmp("rnd_div_err", 64'(div_err), 64'(m_err));
        if (flush) begin
            m_second = 0; m_busy = 0; m_done = 0;
        end else begin
            if (go_madd) m_hilo = mul_res;
            if (go_msub) m_hilo = 64'd0 - mul_res;
            m_second = go_madd || go_msub;
            m_done   = m_busy && div_ready;
            if (m_done) m_res = div_result;
            if (timeout) m_err = 1;
            if (go_div || go_divu) begin
                m_busy = 1; m_age = 0; m_signed = go_div;
            end else if (m_busy) begin
                if (div_ready || timeout) m_busy = 0;
                else m_age++;
            end
        end
    endtask

    typedef struct {
        logic        fl, sif, sid, valid;
        logic [2:0]  op;
        logic [63:0] mul;
        logic [5:0]  e_stall;
        logic        e_cnt;
        logic [63:0] e_hilo;
    } vec_t;

    vec_t vecs[11];

    initial begin
        vecs[0]  = '{0, 1, 1, 0, 3'd0, 64'd0,  6'b000111, 0, 64'd0};
        vecs[1]  = '{0, 1, 0, 0, 3'd0, 64'd0,  6'b000011, 0, 64'd0};
        vecs[2]  = '{1, 0, 1, 0, 3'd0, 64'd0,  6'b000000, 0, 64'd0};
        vecs[3]  = '{0, 0, 1, 0, 3'd1, 64'd9,  6'b000111, 0, 64'd0};
        vecs[4]  = '{0, 0, 0, 1, 3'd1, 64'd6,  6'b001111, 0, 64'd0};
        vecs[5]  = '{0, 0, 0, 1, 3'd1, 64'd99, 6'b000000, 1, 64'd6};
        vecs[6]  = '{0, 0, 0, 0, 3'd0, 64'd0,  6'b000000, 0, 64'd6};
        vecs[7]  = '{0, 0, 0, 1, 3'd2, 64'd5,  6'b001111, 0, 64'd6};
        vecs[8]  = '{0, 0, 1, 0, 3'd0, 64'd0,  6'b000111, 1, 64'hFFFF_FFFF_FFFF_FFFB};
        vecs[9]  = '{1, 0, 0, 1, 3'd1, 64'd7,  6'b000000, 0, 64'hFFFF_FFFF_FFFF_FFFB};
        vecs[10] = '{0, 0, 0, 0, 3'd0, 64'd0,  6'b000000, 0, 64'hFFFF_FFFF_FFFF_FFFB};

        // Reset held with random inputs: everything quiet.
        rst = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            flush = 1'($urandom); stallreq_if = 1'($urandom); stallreq_id = 1'($urandom);
            ex_valid = 1'($urandom); ex_op = 3'($urandom); div_ready = 1'($urandom);
            mul_res = {$urandom, $urandom}; div_result = {$urandom, $urandom};
            #1;
            cmp("rst_stall", 64'(stall), 64'd0);
            cmp("rst_hilo", hilo_temp, 64'd0);
            cmp("rst_flags", 64'({cnt, div_start, div_signed, div_annul, div_done, div_err}), 64'd0);
            cmp("rst_div_res", div_res, 64'd0);
        end
        @(negedge clk); drive_idle(); rst = 1; #1;
        cmp("post_rst_stall", 64'(stall), 64'd0);
        cmp("post_rst_flags", 64'({cnt, div_start, div_annul, div_done}), 64'd0);

        // Vector table: stall priority, MADD/MSUB sequencing, flush of an issue.
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            drive_idle();
            flush = vecs[i].fl; stallreq_if = vecs[i].sif; stallreq_id = vecs[i].sid;
            ex_valid = vecs[i].valid; ex_op = vecs[i].op; mul_res = vecs[i].mul;
            #1;
            cmp($sformatf("vec%0d_stall", i), 64'(stall), 64'(vecs[i].e_stall));
            cmp($sformatf("vec%0d_cnt", i), 64'(cnt), 64'(vecs[i].e_cnt));
            cmp($sformatf("vec%0d_hilo", i), hilo_temp, vecs[i].e_hilo);
        end

        // Signed divide, ready on the 34th cycle of div_start.
        @(negedge clk); drive_idle(); ex_valid = 1; ex_op = 3'd3; #1;
        cmp("div_issue_stall", 64'(stall), 64'(6'b001111));
        cmp("div_issue_start", 64'(div_start), 64'd0);
        for (int k = 1; k <= 34; k++) begin
            @(negedge clk); drive_idle();
            div_ready = (k == 34); div_result = 64'h0000_0001_0000_0003; #1;
            cmp($sformatf("div_wait%0d_stall", k), 64'(stall), 64'(6'b001111));
            cmp($sformatf("div_wait%0d_start", k), 64'(div_start), 64'd1);
            cmp($sformatf("div_wait%0d_signed", k), 64'(div_signed), 64'd1);
            cmp($sformatf("div_wait%0d_done", k), 64'(div_done), 64'd0);
        end
        @(negedge clk); drive_idle(); #1;
        cmp("div_done", 64'(div_done), 64'd1);
        cmp("div_done_res", div_res, 64'h0000_0001_0000_0003);
        cmp("div_done_stall", 64'(stall), 64'd0);
        cmp("div_done_start", 64'(div_start), 64'd0);
        @(negedge clk); #1;
        cmp("div_after_done", 64'(div_done), 64'd0);

        // Unsigned divide flushed on wait cycle 10, late ready ignored.
        @(negedge clk); drive_idle(); ex_valid = 1; ex_op = 3'd4; #1;
        cmp("fl_issue_stall", 64'(stall), 64'(6'b001111));
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk); drive_idle(); flush = (k == 10); #1;
            cmp($sformatf("fl_wait%0d_annul", k), 64'(div_annul), 64'(k == 10));
            cmp($sformatf("fl_wait%0d_signed", k), 64'(div_signed), 64'd0);
        end
        cmp("fl_stall", 64'(stall), 64'd0);
        @(negedge clk); drive_idle(); div_ready = 1; div_result = 64'hDEAD; #1;
        cmp("fl_late_start", 64'(div_start), 64'd0);
        cmp("fl_late_annul", 64'(div_annul), 64'd0);
        @(negedge clk); drive_idle(); #1;
        cmp("fl_late_done", 64'(div_done), 64'd0);
        cmp("fl_late_res", div_res, 64'h0000_0001_0000_0003);

        // Timeout: no ready for 40 wait cycles.
        @(negedge clk); drive_idle(); ex_valid = 1; ex_op = 3'd3; #1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk); drive_idle(); #1;
            cmp($sformatf("to_wait%0d_annul", k), 64'(div_annul), 64'(k == 40));
            cmp($sformatf("to_wait%0d_stall", k), 64'(stall), 64'(6'b001111));
            cmp($sformatf("to_wait%0d_err", k), 64'(div_err), 64'd0);
        end
        @(negedge clk); drive_idle(); #1;
        cmp("to_err", 64'(div_err), 64'd1);
        cmp("to_start", 64'(div_start), 64'd0);
        cmp("to_done", 64'(div_done), 64'd0);
        cmp("to_stall", 64'(stall), 64'd0);
        @(negedge clk); drive_idle(); flush = 1; #1;
        @(negedge clk); drive_idle(); ex_valid = 1; ex_op = 3'd1; mul_res = 64'd3; #1;
        cmp("to_err_sticky", 64'(div_err), 64'd1);
        cmp("to_b2b_madd_stall", 64'(stall), 64'(6'b001111));

        // Random stimulus against the model, from a fresh reset.
        @(negedge clk); drive_idle(); rst = 0;
        @(negedge clk); rst = 1; model_reset();
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            flush       = ($urandom_range(0, 39) == 0);
            stallreq_if = 1'($urandom);
            stallreq_id = ($urandom_range(0, 3) == 0);
            ex_valid    = 1'($urandom);
            ex_op       = 3'($urandom_range(0, 7));
            mul_res     = {$urandom, $urandom};
            div_ready   = ($urandom_range(0, 24) == 0);
            div_result  = {$urandom, $urandom};
            #1;
            model_check_and_step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
